// File: rtl/md_seq_ctrl.sv
// md_seq_ctrl: RV32M multiply/divide sequencer for the EX stage.
// Radix-2 shift-add multiply and restoring divide, one bit per cycle.
// Divide-by-zero and signed overflow are resolved without iterating.
// Optional build macro MD_FAST_MUL_EN: multiplies finish in a single cycle,
// computed in IDLE; divides still iterate.
module md_seq_ctrl #(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic [2:0]      i_f3,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_rs2,
  input  logic            i_flush,
  output logic            o_busy,
  output logic            o_stall,
  output logic            o_valid,
  output logic [XLEN-1:0] o_result
);

  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [CW-1:0]   CNT_INIT = CW'(XLEN);
  localparam logic [CW-1:0]   CNT_LAST = CW'(1);
  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [2:0]        r_f3;
  logic [CW-1:0]     r_cnt;
  // Multiply: {partial product high, multiplier shifting out}.
  // Divide:   {partial remainder, dividend shifting out / quotient shifting in}.
  logic [2*XLEN-1:0] r_acc;
  // Multiplicand for multiply, divisor for divide (magnitude).
  logic [XLEN-1:0]   r_b;
  logic              r_neg;
  logic [XLEN-1:0]   r_result;

  logic              w_a_signed;
  logic              w_b_signed;
  logic              w_a_neg;
  logic              w_b_neg;
  logic [XLEN-1:0]   w_a_abs;
  logic [XLEN-1:0]   w_b_abs;
  logic              w_neg_flag;
  logic              w_div_zero;
  logic              w_div_ovf;
  logic              w_special;
  logic [XLEN-1:0]   w_special_result;
  logic              w_fast_hit;
  logic [XLEN-1:0]   w_fast_result;
  logic              w_accept;

  logic [XLEN:0]     w_mul_sum;
  logic [2*XLEN-1:0] w_mul_step;
  logic [XLEN:0]     w_trial;
  logic [2*XLEN-1:0] w_div_step;
  logic [2*XLEN-1:0] w_mul_full;
  logic [XLEN-1:0]   w_quo;
  logic [XLEN-1:0]   w_rem;
  logic [XLEN-1:0]   w_fix_result;

  assign w_accept = i_start & ~i_flush;

  // Operand decode for the incoming request: signedness, magnitudes, special cases.
  always_comb begin
    w_a_signed = 1'b1;
    w_b_signed = 1'b1;
    case (i_f3)
      3'b010:  w_b_signed = 1'b0;                              // MULHSU
      3'b011, 3'b101, 3'b111: begin                            // MULHU, DIVU, REMU
        w_a_signed = 1'b0;
        w_b_signed = 1'b0;
      end
      default: begin
        w_a_signed = 1'b1;
        w_b_signed = 1'b1;
      end
    endcase
    w_a_neg = w_a_signed & i_rs1[XLEN-1];
    w_b_neg = w_b_signed & i_rs2[XLEN-1];
    w_a_abs = w_a_neg ? -i_rs1 : i_rs1;
    w_b_abs = w_b_neg ? -i_rs2 : i_rs2;
    // Remainder takes the dividend's sign; everything else the XOR of signs.
    w_neg_flag = (i_f3[2] & i_f3[1]) ? w_a_neg : (w_a_neg ^ w_b_neg);
    w_div_zero = i_f3[2] & (i_rs2 == '0);
    w_div_ovf  = i_f3[2] & ~i_f3[0] & (i_rs1 == MIN_NEG) & (i_rs2 == '1);
    w_special  = w_div_zero | w_div_ovf;
    if (w_div_zero) begin
      w_special_result = i_f3[1] ? i_rs1 : '1;
    end else begin
      w_special_result = i_f3[1] ? '0 : MIN_NEG;
    end
  end

`ifdef MD_FAST_MUL_EN
  logic [XLEN:0]     w_fa;
  logic [XLEN:0]     w_fb;
  logic [2*XLEN-1:0] w_fa_ext;
  logic [2*XLEN-1:0] w_fb_ext;
  logic [2*XLEN-1:0] w_fprod;

  // Single-cycle multiply on (XLEN+1)-bit sign-extended operands; low 2*XLEN bits are exact.
  always_comb begin
    w_fa          = {w_a_signed & i_rs1[XLEN-1], i_rs1};
    w_fb          = {w_b_signed & i_rs2[XLEN-1], i_rs2};
    w_fa_ext      = {{(XLEN-1){w_fa[XLEN]}}, w_fa};
    w_fb_ext      = {{(XLEN-1){w_fb[XLEN]}}, w_fb};
    w_fprod       = w_fa_ext * w_fb_ext;
    w_fast_hit    = ~i_f3[2];
    w_fast_result = (i_f3[1:0] == 2'b00) ? w_fprod[XLEN-1:0] : w_fprod[2*XLEN-1:XLEN];
  end
`else
  assign w_fast_hit    = 1'b0;
  assign w_fast_result = '0;
`endif

  // One iteration step for each algorithm plus the final sign fix/select.
  always_comb begin
    w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, r_b};
    w_mul_step = r_acc[0] ? {w_mul_sum, r_acc[XLEN-1:1]} : {1'b0, r_acc[2*XLEN-1:1]};
    // Trial subtract of the divisor from {remainder, next dividend bit}.
    w_trial    = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]} - {1'b0, r_b};
    w_div_step = w_trial[XLEN] ? {r_acc[2*XLEN-2:0], 1'b0}
                               : {w_trial[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
    w_mul_full = r_neg ? -r_acc : r_acc;
    w_quo      = r_neg ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
    w_rem      = r_neg ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];
    if (r_f3[2]) begin
      w_fix_result = r_f3[1] ? w_rem : w_quo;
    end else if (r_f3[1:0] == 2'b00) begin
      w_fix_result = w_mul_full[XLEN-1:0];
    end else begin
      w_fix_result = w_mul_full[2*XLEN-1:XLEN];
    end
  end

  // State register; reset overrides everything.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    w_state_next = r_state;
    o_busy       = (r_state != S_IDLE);
    o_stall      = 1'b0;
    o_valid      = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_stall = w_accept;
        if (w_accept) begin
          w_state_next = (w_special | w_fast_hit) ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        o_stall = 1'b1;
        if (i_flush) begin
          w_state_next = S_IDLE;
        end else if (r_cnt == CNT_LAST) begin
          w_state_next = S_FIX;
        end
      end
      S_FIX: begin
        o_stall      = 1'b1;
        w_state_next = i_flush ? S_IDLE : S_DONE;
      end
      S_DONE: begin
        o_valid      = ~i_flush;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Datapath: latch operands, iterate, and register the result before DONE.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_f3     <= '0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_b      <= '0;
      r_neg    <= 1'b0;
      r_result <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_f3  <= i_f3;
            r_neg <= w_neg_flag;
            r_b   <= i_f3[2] ? w_b_abs : w_a_abs;
            r_acc <= {{XLEN{1'b0}}, (i_f3[2] ? w_a_abs : w_b_abs)};
            if (w_special) begin
              r_result <= w_special_result;
            end else if (w_fast_hit) begin
              r_result <= w_fast_result;
            end else begin
              r_cnt <= CNT_INIT;
            end
          end
        end
        S_CALC: begin
          if (i_flush) begin
            r_cnt <= '0;
          end else begin
            r_cnt <= r_cnt - CNT_LAST;
            r_acc <= r_f3[2] ? w_div_step : w_mul_step;
          end
        end
        S_FIX: begin
          if (!i_flush) begin
            r_result <= w_fix_result;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign o_result = r_result;

endmodule

// File: tb/tb_md_seq_ctrl.sv
// tb_md_seq_ctrl: directed checks from the test plan, then randomized traffic
// checked every cycle against a behavioural model (plain arithmetic + countdown).
module tb_md_seq_ctrl;
  localparam int XLEN = 32;
`ifdef MD_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 34;
`endif

  logic        clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_start = 1'b0;
  logic [2:0]  i_f3 = '0;
  logic [31:0] i_rs1 = '0;
  logic [31:0] i_rs2 = '0;
  logic        i_flush = 1'b0;
  logic        o_busy, o_stall, o_valid;
  logic [31:0] o_result;

  md_seq_ctrl #(.XLEN(XLEN)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_f3(i_f3),
    .i_rs1(i_rs1), .i_rs2(i_rs2), .i_flush(i_flush),
    .o_busy(o_busy), .o_stall(o_stall), .o_valid(o_valid), .o_result(o_result)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  // Model: m_cnt = cycles since accepted start (0 = idle), m_lat = cycle of o_valid.
  int          m_cnt = 0;
  int          m_lat = 0;
  logic [31:0] m_exp = '0;
  logic [31:0] m_result = '0;
  bit          m_init = 0;

  function automatic logic [31:0] ref_md(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    p  = '0;
    case (f3)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (!f3[2]) return MUL_LAT;
    if (b == 0) return 1;
    if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 34;
  endfunction

  // Model advance at each active edge, using the same inputs the DUT samples.
  always @(posedge clk) begin
    cyc++;
    if (i_rst) begin
      m_cnt = 0; m_result = '0; m_init = 1;
    end else if (m_cnt == 0) begin
      if (i_start && !i_flush) begin
        m_exp = ref_md(i_f3, i_rs1, i_rs2);
        m_lat = ref_lat(i_f3, i_rs1, i_rs2);
        if (m_lat == 1) m_result = m_exp;
        m_cnt = 1;
      end
    end else if (i_flush) begin
      m_cnt = 0;
    end else begin
      if (m_cnt == m_lat - 1) m_result = m_exp;
      if (m_cnt == m_lat) m_cnt = 0;
      else m_cnt = m_cnt + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  // Per-cycle compare of every output against the model.
  always @(negedge clk) begin
    if (m_init) begin
      check("busy", {31'b0, o_busy}, {31'b0, m_cnt != 0});
      check("stall", {31'b0, o_stall},
            {31'b0, (m_cnt == 0 && i_start && !i_flush) || (m_cnt != 0 && m_cnt < m_lat)});
      check("valid", {31'b0, o_valid}, {31'b0, m_cnt != 0 && m_cnt == m_lat && !i_flush});
      check("result", o_result, m_result);
    end
  end

  task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] want, input int want_lat);
    int s;
    int got;
    logic [31:0] res;
    got = -1;
    res = '0;
    check({name, "_model"}, ref_md(f3, a, b), want);
    @(posedge clk); #1;
    i_f3 = f3; i_rs1 = a; i_rs2 = b; i_start = 1'b1; s = cyc;
    @(posedge clk); #1;
    i_start = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (o_valid === 1'b1) begin got = cyc - s; res = o_result; break; end
    end
    check({name, "_lat"}, got, want_lat);
    check({name, "_res"}, res, want);
    $display("op %s f3=%0d a=%h b=%h -> %h after %0d cycles", name, f3, a, b, res, got);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 15));
      4: return -32'($urandom_range(1, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int s;
    int got;
    logic [31:0] res;
    bit saw;
    repeat (3) @(posedge clk);
    #1 i_rst = 1'b0;

    run_op("div_neg7_2",  3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
    run_op("rem_neg7_2",  3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
    run_op("divu_by0",    3'b101, 32'd100, 32'd0, 32'hFFFF_FFFF, 1);
    run_op("remu_by0",    3'b111, 32'd100, 32'd0, 32'd100, 1);
    run_op("div_ovf",     3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("rem_ovf",     3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1);
    run_op("mul_6x7",     3'b000, 32'd6, 32'd7, 32'd42, MUL_LAT);
    run_op("mulh_m1m1",   3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, MUL_LAT);
    run_op("mulhu_m1m1",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT);
    run_op("mulhsu_m1x2", 3'b010, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, MUL_LAT);

    // Flush in cycle 10 of DIVU 1000/3, then DIVU 9/3 starting in cycle 11.
    @(posedge clk); #1;
    i_f3 = 3'b101; i_rs1 = 32'd1000; i_rs2 = 32'd3; i_start = 1'b1; s = cyc;
    @(posedge clk); #1;
    i_start = 1'b0; saw = 0;
    while (cyc < s + 10) begin
      @(negedge clk); if (o_valid !== 1'b0) saw = 1;
      @(posedge clk); #1;
    end
    i_flush = 1'b1;
    @(posedge clk); #1;
    i_flush = 1'b0; i_f3 = 3'b101; i_rs1 = 32'd9; i_rs2 = 32'd3; i_start = 1'b1;
    @(negedge clk);
    check("flush_busy", {31'b0, o_busy}, 32'd0);
    check("flush_novalid", {31'b0, saw}, 32'd0);
    @(posedge clk); #1;
    i_start = 1'b0; got = -1; res = '0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (o_valid === 1'b1) begin got = cyc - s; res = o_result; break; end
    end
    check("after_flush_lat", got, 45);
    check("after_flush_res", res, 32'd3);
    $display("op flush_then_divu 9/3 -> %h at cycle %0d", res, got);

    // Reset in cycle 5 of a DIV.
    @(posedge clk); #1;
    i_f3 = 3'b100; i_rs1 = 32'd12345; i_rs2 = 32'd7; i_start = 1'b1; s = cyc;
    @(posedge clk); #1;
    i_start = 1'b0;
    while (cyc < s + 5) begin @(posedge clk); #1; end
    i_rst = 1'b1;
    @(posedge clk); #1;
    i_rst = 1'b0;
    @(negedge clk);
    check("rst_busy", {31'b0, o_busy}, 32'd0);
    check("rst_valid", {31'b0, o_valid}, 32'd0);
    check("rst_result", o_result, 32'd0);
    check("rst_stall", {31'b0, o_stall}, 32'd0);
    $display("op reset_mid_div busy=%b valid=%b result=%h", o_busy, o_valid, o_result);

    // Randomized traffic; the per-cycle compare does the checking.
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      i_start = ($urandom_range(0, 3) != 0);
      i_flush = ($urandom_range(0, 40) == 0);
      i_rst   = ($urandom_range(0, 700) == 0);
      i_f3    = 3'($urandom_range(0, 7));
      i_rs1   = pick();
      i_rs2   = pick();
    end
    @(posedge clk); #1;
    i_start = 1'b0; i_flush = 1'b0; i_rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
